// File: rtl/spi_flash_pkg.sv
// Shared constants, FSM encoding and helpers for the SPI flash read master.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_QREAD   = 8'hEB;
  localparam logic [7:0] QMODE_BYTE = 8'h00;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned ADDR_BITS = 24;
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_GAP
  } state_e;

  // First byte received sits in [31:24] of the shift-in register; responses are little-endian.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_sck_gen.sv
// SPI mode-0 clock generator: CLK_DIV cycles low then CLK_DIV cycles high while enabled.
module spi_flash_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          half_end;

  // Strobes flag the cycle whose closing edge toggles sck.
  always_comb begin
    half_end = en && (cnt_q == LAST);
    rise_c   = half_end && !sck_q;
    fall_c   = half_end && sck_q;
    cnt_d    = '0;
    sck_d    = 1'b0;
    if (en) begin
      cnt_d = half_end ? '0 : cnt_q + CW'(1);
      sck_d = half_end ? ~sck_q : sck_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck = sck_q;

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash read master: 03h single or EBh quad (mode byte 00h) word reads.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter int unsigned CSB_HIGH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic        req_quad,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic [3:0]  flash_io_do,
  output logic [3:0]  flash_io_oe,
  input  logic [3:0]  flash_io_di
);

  import spi_flash_pkg::*;

  state_e           state_q, state_d;
  logic             quad_q, quad_d;
  logic [23:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last;
  logic [31:0]      sout_q, sout_d;
  logic [31:0]      sin_q, sin_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             csb_q, csb_d;
  logic [3:0]       do_q, do_d;
  logic [3:0]       oe_q, oe_d;
  logic             sck_en, rise_c, fall_c;

  assign sck_en = (state_q != ST_IDLE) && (state_q != ST_GAP);

  spi_flash_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk    (clk),
    .reset  (reset),
    .en     (sck_en),
    .sck    (flash_clk),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  always_comb begin
    state_d     = state_q;
    quad_d      = quad_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    sout_d      = sout_q;
    sin_d       = sin_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    do_d        = 4'h0;
    oe_d        = 4'h0;

    // Index of the final flash_clk cycle (or gap cycle) of the current phase.
    case (state_q)
      ST_CMD:   last = CNT_W'(CMD_BITS - 1);
      ST_ADDR:  last = quad_q ? CNT_W'(ADDR_BITS / 4 - 1) : CNT_W'(ADDR_BITS - 1);
      ST_MODE:  last = CNT_W'(8 / 4 - 1);
      ST_DUMMY: last = CNT_W'(DUMMY_CYCLES - 1);
      ST_DATA:  last = quad_q ? CNT_W'(DATA_BITS / 4 - 1) : CNT_W'(DATA_BITS - 1);
      ST_GAP:   last = CNT_W'(CSB_HIGH - 2);
      default:  last = '0;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = ST_CMD;
          quad_d  = req_quad;
          addr_d  = req_addr;
          cnt_d   = '0;
          sout_d  = {req_quad ? OP_QREAD : OP_READ, 24'h0};
        end
      end
      ST_GAP: begin
        if (cnt_q == last) state_d = ST_IDLE;
        else               cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        if (rise_c && (state_q == ST_DATA)) begin
          sin_d = quad_q ? {sin_q[27:0], flash_io_di} : {sin_q[30:0], flash_io_di[1]};
        end
        // Outputs only move on the falling edge, at the start of a bit period.
        if (fall_c) begin
          if (cnt_q == last) begin
            cnt_d = '0;
            case (state_q)
              ST_CMD: begin
                state_d = ST_ADDR;
                sout_d  = {addr_q, 8'h00};
              end
              ST_ADDR: begin
                state_d = quad_q ? ST_MODE : ST_DATA;
                sout_d  = {QMODE_BYTE, 24'h0};
              end
              ST_MODE:  state_d = (DUMMY_CYCLES != 0) ? ST_DUMMY : ST_DATA;
              ST_DUMMY: state_d = ST_DATA;
              ST_DATA: begin
                state_d     = (CSB_HIGH > 1) ? ST_GAP : ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = byte_swap32(sin_q);
              end
              default: state_d = ST_IDLE;
            endcase
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            sout_d = (quad_q && (state_q != ST_CMD)) ? {sout_q[27:0], 4'h0}
                                                     : {sout_q[30:0], 1'b0};
          end
        end
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    csb_d   = (state_d == ST_IDLE) || (state_d == ST_GAP);
    case (state_d)
      ST_CMD: begin
        oe_d = 4'b0001;
        do_d = {3'b000, sout_d[31]};
      end
      ST_ADDR: begin
        oe_d = quad_d ? 4'b1111 : 4'b0001;
        do_d = quad_d ? sout_d[31:28] : {3'b000, sout_d[31]};
      end
      ST_MODE: begin
        oe_d = 4'b1111;
        do_d = sout_d[31:28];
      end
      default: begin
        oe_d = 4'h0;
        do_d = 4'h0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      quad_q      <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      sout_q      <= '0;
      sin_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      csb_q       <= 1'b1;
      do_q        <= 4'h0;
      oe_q        <= 4'h0;
    end else begin
      state_q     <= state_d;
      quad_q      <= quad_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      sout_q      <= sout_d;
      sin_q       <= sin_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      csb_q       <= csb_d;
      do_q        <= do_d;
      oe_q        <= oe_d;
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign flash_csb   = csb_q;
  assign flash_io_do = do_q;
  assign flash_io_oe = oe_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Randomized bench for spi_flash_reader against a behavioural SPI flash and word-read reference.
module tb_spi_flash_reader;

  localparam int unsigned DUMMY = 8;
  localparam int unsigned CSBH  = 2;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        req_valid = 1'b0;
  logic [23:0] req_addr  = '0;
  logic        req_quad  = 1'b0;
  logic        sel       = 1'b0;
  logic [3:0]  di_m      = '0;

  logic        rdy0, rdy1, rv0, rv1, csb0, csb1, fclk0, fclk1;
  logic [31:0] rd0, rd1;
  logic [3:0]  do0, do1, oe0, oe1;
  logic        rdy_s, rv_s, csb_s, fclk_s;
  logic [31:0] rd_s;
  logic [3:0]  do_s, oe_s;

  spi_flash_reader #(.CLK_DIV(2), .DUMMY_CYCLES(DUMMY), .CSB_HIGH(CSBH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy0),
    .req_addr(req_addr), .req_quad(req_quad), .rsp_valid(rv0), .rsp_data(rd0),
    .flash_csb(csb0), .flash_clk(fclk0), .flash_io_do(do0), .flash_io_oe(oe0),
    .flash_io_di(di_m));

  spi_flash_reader #(.CLK_DIV(1), .DUMMY_CYCLES(DUMMY), .CSB_HIGH(CSBH)) dut_div1 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy1),
    .req_addr(req_addr), .req_quad(req_quad), .rsp_valid(rv1), .rsp_data(rd1),
    .flash_csb(csb1), .flash_clk(fclk1), .flash_io_do(do1), .flash_io_oe(oe1),
    .flash_io_di(di_m));

  assign rdy_s  = sel ? rdy1  : rdy0;
  assign rv_s   = sel ? rv1   : rv0;
  assign rd_s   = sel ? rd1   : rd0;
  assign csb_s  = sel ? csb1  : csb0;
  assign fclk_s = sel ? fclk1 : fclk0;
  assign do_s   = sel ? do1   : do0;
  assign oe_s   = sel ? oe1   : oe0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  // Flash contents: explicit bytes override a fixed address hash.
  logic [7:0] mem [int unsigned];

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    if (mem.exists(32'(a))) return mem[32'(a)];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_rd(24'(a + 24'(i)));
    return w;
  endfunction

  typedef struct {
    logic [23:0] a;
    logic        q;
    int          c;
    int          div;
  } txn_t;

  txn_t acc_q[$];
  int   n_rsp    = 0;
  int   hi_run   = 0;
  int   last_gap = 0;

  int         nrise     = 0;
  logic [7:0] m_cmd     = '0;
  logic [23:0] m_addr   = '0;
  logic [7:0] m_mode    = '0;
  logic       m_oe_bad  = 1'b0;
  logic       fclk_prev = 1'b0;

  task automatic hdr_check(input logic q);
    if (acc_q.size() == 0) begin
      chk("hdr_txn", 32'(acc_q.size()), 1);
    end else begin
      chk("cmd", m_cmd, acc_q[0].q ? 8'hEB : 8'h03);
      chk("addr", m_addr, acc_q[0].a);
      if (q) chk("mode_byte", m_mode, 8'h00);
    end
  endtask

  task automatic flash_rise();
    nrise++;
    if (nrise <= 8) begin
      m_cmd = {m_cmd[6:0], do_s[0]};
    end else if (m_cmd == 8'hEB) begin
      if (nrise <= 14)              m_addr = {m_addr[19:0], do_s};
      else if (nrise <= 16)         m_mode = {m_mode[3:0], do_s};
      else if (nrise <= 16 + DUMMY) begin
        if (oe_s !== 4'h0) m_oe_bad = 1'b1;
      end
      if (nrise == 16)        hdr_check(1'b1);
      if (nrise == 17 + DUMMY) chk("dummy_oe", 32'(m_oe_bad), 0);
    end else begin
      if (nrise <= 32) m_addr = {m_addr[22:0], do_s[0]};
      if (nrise == 32) hdr_check(1'b0);
    end
  endtask

  task automatic flash_fall();
    int k;
    logic [7:0] b;
    logic [3:0] n;
    if (m_cmd == 8'hEB) begin
      if (nrise >= 16 + DUMMY) begin
        k = nrise - 16 - DUMMY;
        b = mem_rd(24'(m_addr + 24'(k / 2)));
        di_m = (k % 2 == 0) ? b[7:4] : b[3:0];
      end
    end else if (nrise >= 32) begin
      k = nrise - 32;
      b = mem_rd(24'(m_addr + 24'(k / 8)));
      n = 4'($urandom);
      n[1] = b[7 - (k % 8)];
      di_m = n;
    end
  endtask

  // Scoreboard, chip-select gap monitor and flash model, all sampled on the falling clk edge.
  always @(negedge clk) begin
    if (reset) begin
      nrise     = 0;
      di_m      = '0;
      fclk_prev = 1'b0;
    end else begin
      if (req_valid && rdy_s) acc_q.push_back('{a: req_addr, q: req_quad, c: cyc, div: sel ? 1 : 2});
      if (rv_s) begin
        txn_t e;
        n_rsp++;
        if (acc_q.size() == 0) begin
          chk("rsp_unexpected", 32'(acc_q.size()), 1);
        end else begin
          e = acc_q.pop_front();
          chk("rsp_data", rd_s, exp_word(e.a));
          chk("latency", 32'(cyc - e.c), 32'(1 + 2 * e.div * (e.q ? 24 + DUMMY : 64)));
        end
      end
      if (csb_s) hi_run++;
      else begin
        if (hi_run > 0) last_gap = hi_run;
        hi_run = 0;
      end
      if (csb_s) begin
        nrise    = 0;
        m_oe_bad = 1'b0;
        di_m     = '0;
      end else if (fclk_s && !fclk_prev) flash_rise();
      else if (!fclk_s && fclk_prev)     flash_fall();
      fclk_prev = fclk_s;
    end
  end

  task automatic issue(input logic [23:0] a, input logic q, input logic hold);
    int n;
    @(posedge clk);
    #1;
    req_addr  = a;
    req_quad  = q;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rdy_s && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n >= 5000), 0);
    @(posedge clk);
    #1;
    if (!hold || n >= 5000) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (acc_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_pending", 32'(acc_q.size()), 0);
    acc_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int seen;
    int n;
    mem[32'h100]    = 8'h11;
    mem[32'h101]    = 8'h22;
    mem[32'h102]    = 8'h33;
    mem[32'h103]    = 8'h44;
    mem[32'hFFFFFE] = 8'hAA;
    mem[32'hFFFFFF] = 8'hBB;
    mem[32'h0]      = 8'hCC;
    mem[32'h1]      = 8'hDD;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csb", 32'(csb_s), 1);
    chk("rst_fclk", 32'(fclk_s), 0);
    chk("rst_oe", 32'(oe_s), 0);
    chk("rst_do", 32'(do_s), 0);
    chk("rst_rsp_valid", 32'(rv_s), 0);
    chk("rst_rsp_data", rd_s, 0);
    chk("rst_ready", 32'(rdy_s), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy_s), 1);

    issue(24'h000100, 1'b0, 1'b0);
    wait_idle();
    issue(24'h000100, 1'b1, 1'b0);
    wait_idle();

    // Wrap read immediately followed by a quad read with req_valid held.
    issue(24'hFFFFFE, 1'b0, 1'b1);
    issue(24'h000100, 1'b1, 1'b0);
    wait_idle();
    chk("csb_gap", 32'(last_gap), CSBH);

    // Abort a quad read in the middle of its data phase.
    issue(24'h000100, 1'b1, 1'b0);
    n = 0;
    while (nrise < 26 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("reach_data", 32'(nrise >= 26), 1);
    seen = n_rsp;
    #2 reset = 1'b1;
    #1;
    chk("abort_csb", 32'(csb_s), 1);
    chk("abort_fclk", 32'(fclk_s), 0);
    acc_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_no_rsp", 32'(n_rsp - seen), 0);
    issue(24'h000100, 1'b0, 1'b0);
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      logic [23:0] a;
      logic        q;
      logic        hold;
      a    = ($urandom_range(0, 3) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3)) : 24'($urandom);
      q    = 1'($urandom);
      hold = (i != 11) && ($urandom_range(0, 2) == 0);
      if (acc_q.size() == 0) begin
        for (int j = 0; j < 4; j++) mem[32'(24'(a + 24'(j)))] = 8'($urandom);
      end
      issue(a, q, hold);
      if (!hold) wait_idle();
    end

    // Same checks on the CLK_DIV=1 instance.
    @(negedge clk);
    sel = 1'b1;
    issue(24'h000100, 1'b0, 1'b0);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      logic [23:0] a;
      logic        q;
      a = 24'($urandom);
      q = 1'($urandom);
      issue(a, q, 1'b0);
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
